prog_clock_divider: RTL and testbench

// Multi-channel, runtime-programmable clock divider. Each of CHANNELS channels

---
 rtl/prog_clock_divider.sv | 124 ++++++++++++
 tb/tb_prog_clock_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider with registered clock/tick outputs.
// Divisors load through a valid/ready port and take effect only at a period boundary.
module prog_clock_divider #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SEL_WIDTH   = 1,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CHANNELS-1:0]  i_en,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [SEL_WIDTH-1:0] i_cfg_chan,
  input  logic [CNT_WIDTH-1:0] i_cfg_div,
  output logic                 o_cfg_err,
  output logic [CHANNELS-1:0]  o_pending,
  output logic [CHANNELS-1:0]  o_clk_out,
  output logic [CHANNELS-1:0]  o_tick
);

  localparam logic [CNT_WIDTH-1:0] DefDiv    = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [SEL_WIDTH:0]   ChanLimit = (SEL_WIDTH + 1)'(CHANNELS);

  logic r_cfg_ready;
  logic r_cfg_err;
  logic w_xfer;
  logic w_reject;
  logic w_accept;

  assign w_xfer   = i_cfg_valid && r_cfg_ready;
  assign w_reject = (i_cfg_div < CNT_WIDTH'(2)) || ({1'b0, i_cfg_chan} >= ChanLimit);
  assign w_accept = w_xfer && !w_reject;

  // Every transfer, accepted or not, costs one cycle of ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_ready <= !w_xfer;
      r_cfg_err   <= w_xfer && w_reject;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_err   = r_cfg_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_div_act;
    logic [CNT_WIDTH-1:0] w_div_nxt;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic [CNT_WIDTH-1:0] w_shadow_nxt;
    logic                 r_running;
    logic                 w_running_nxt;
    logic                 r_pending;
    logic                 w_pending_nxt;
    logic                 r_clk;
    logic                 r_tick;
    logic                 w_wrap;
    logic                 w_sel;

    assign w_sel  = w_accept && (i_cfg_chan == SEL_WIDTH'(g));
    assign w_wrap = r_running && i_en[g] && (r_cnt == r_div_act - CNT_WIDTH'(1));

    always_comb begin
      w_cnt_nxt     = r_cnt;
      w_div_nxt     = r_div_act;
      w_shadow_nxt  = r_shadow;
      w_running_nxt = r_running;
      w_pending_nxt = r_pending;

      if (!i_en[g]) begin
        w_running_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end else if (!r_running) begin
        w_running_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end else begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_WIDTH'(1);
      end

      if (r_pending && (!r_running || w_wrap)) begin
        w_div_nxt     = r_shadow;
        w_pending_nxt = 1'b0;
      end

      // A same-edge write lands after the apply, so it waits for the next boundary.
      if (w_sel) begin
        w_shadow_nxt  = i_cfg_div;
        w_pending_nxt = 1'b1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_cnt     <= '0;
        r_div_act <= DefDiv;
        r_shadow  <= '0;
        r_running <= 1'b0;
        r_pending <= 1'b0;
        r_clk     <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_div_act <= w_div_nxt;
        r_shadow  <= w_shadow_nxt;
        r_running <= w_running_nxt;
        r_pending <= w_pending_nxt;
        r_tick    <= w_running_nxt && (w_cnt_nxt == '0);
        r_clk     <= w_running_nxt && (w_cnt_nxt < (w_div_nxt >> 1));
      end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n) r_cnt < r_div_act);

    assign o_pending[g] = r_pending;
    assign o_clk_out[g] = r_clk;
    assign o_tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: vector table through a scoreboard queue,
// then hand-written multi-cycle sequences checked against closed-form period patterns.
module tb_prog_clock_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_div;
  logic        cfg_err;
  logic [1:0]  pending;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prog_clock_divider #(
    .CHANNELS    (2),
    .CNT_WIDTH   (16),
    .SEL_WIDTH   (2),
    .DEFAULT_DIV (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_chan  (cfg_chan),
    .i_cfg_div   (cfg_div),
    .o_cfg_err   (cfg_err),
    .o_pending   (pending),
    .o_clk_out   (clk_out),
    .o_tick      (tick)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  en;
    logic        valid;
    logic [1:0]  chan;
    logic [15:0] div;
    logic        e_ready;
    logic        e_err;
    logic [1:0]  e_pend;
    logic [1:0]  e_clk;
    logic [1:0]  e_tick;
  } vec_t;

  vec_t vecs[17];
  vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] e, input logic v,
                       input logic [1:0] c, input logic [15:0] d);
    rst_n     = r;
    en        = e;
    cfg_valid = v;
    cfg_chan  = c;
    cfg_div   = d;
  endtask

  // Divisor schedule for the reprogramming sequence: 4, then 6 from k=4, then 8 from k=16.
  function automatic int div_at(input int k);
    if (k < 4) return 4;
    else if (k < 16) return 6;
    else return 8;
  endfunction

  function automatic int cnt_at(input int k);
    if (k < 4) return k;
    else if (k < 16) return (k - 4) % 6;
    else return (k - 16) % 8;
  endfunction

  initial begin
    vec_t exp_v;
    int   ticks;
    int   highs;

    drive(1'b0, 2'b00, 1'b0, 2'd0, 16'd0);

    //            rst   en     v     chan  div     rdy   err   pend   clk    tick
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{1'b1, 2'b01, 1'b1, 2'd0, 16'd1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    vecs[6]  = '{1'b1, 2'b01, 1'b1, 2'd2, 16'd5, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{1'b1, 2'b01, 1'b1, 2'd2, 16'd5, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    vecs[8]  = '{1'b1, 2'b01, 1'b1, 2'd3, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
    vecs[10] = '{1'b1, 2'b01, 1'b1, 2'd1, 16'd3, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
    vecs[14] = '{1'b1, 2'b11, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[15] = '{1'b1, 2'b11, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11};
    vecs[16] = '{1'b1, 2'b00, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].valid, vecs[i].chan, vecs[i].div);
      sb_q.push_back(vecs[i]);
      cyc();
      exp_v = sb_q.pop_front();
      check($sformatf("vec%0d ready", i), 32'(cfg_ready), 32'(exp_v.e_ready));
      check($sformatf("vec%0d err", i), 32'(cfg_err), 32'(exp_v.e_err));
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(exp_v.e_pend));
      check($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(exp_v.e_clk));
      check($sformatf("vec%0d tick", i), 32'(tick), 32'(exp_v.e_tick));
    end

    // Idle ch1: D=5 loads immediately, then runs high 2 / low 3.
    drive(1'b1, 2'b00, 1'b1, 2'd1, 16'd5);
    cyc();
    check("d5 pending set", 32'(pending[1]), 32'd1);
    check("d5 ready low", 32'(cfg_ready), 32'd0);
    drive(1'b1, 2'b00, 1'b0, 2'd0, 16'd0);
    cyc();
    check("d5 pending clear", 32'(pending[1]), 32'd0);
    drive(1'b1, 2'b10, 1'b0, 2'd0, 16'd0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("d5 clk k=%0d", k), 32'(clk_out[1]), 32'((k % 5) < 2));
      check($sformatf("d5 tick k=%0d", k), 32'(tick[1]), 32'((k % 5) == 0));
    end

    drive(1'b1, 2'b00, 1'b1, 2'd1, 16'd6);
    cyc();
    drive(1'b1, 2'b00, 1'b0, 2'd0, 16'd0);
    cyc();
    drive(1'b1, 2'b10, 1'b0, 2'd0, 16'd0);
    for (int k = 0; k < 18; k++) begin
      cyc();
      check($sformatf("d6 clk k=%0d", k), 32'(clk_out[1]), 32'((k % 6) < 3));
      check($sformatf("d6 tick k=%0d", k), 32'(tick[1]), 32'((k % 6) == 0));
    end
    drive(1'b1, 2'b00, 1'b0, 2'd0, 16'd0);
    cyc();

    // ch0 at D=4; D=6 written mid-period, then a held request writes 7 and 8 before a wrap.
    drive(1'b1, 2'b00, 1'b1, 2'd0, 16'd4);
    cyc();
    drive(1'b1, 2'b00, 1'b0, 2'd0, 16'd0);
    cyc();
    for (int k = 0; k < 20; k++) begin
      if (k == 2) drive(1'b1, 2'b01, 1'b1, 2'd0, 16'd6);
      else if (k >= 11 && k <= 14) drive(1'b1, 2'b01, 1'b1, 2'd0, (k < 13) ? 16'd7 : 16'd8);
      else drive(1'b1, 2'b01, 1'b0, 2'd0, 16'd0);
      cyc();
      check($sformatf("reprog clk k=%0d", k), 32'(clk_out[0]),
            32'(cnt_at(k) < div_at(k) / 2));
      check($sformatf("reprog tick k=%0d", k), 32'(tick[0]), 32'(cnt_at(k) == 0));
      check($sformatf("reprog pending k=%0d", k), 32'(pending[0]),
            32'((k >= 2 && k <= 3) || (k >= 11 && k <= 15)));
      check($sformatf("reprog ready k=%0d", k), 32'(cfg_ready),
            32'(!(k == 2 || k == 11 || k == 13)));
      check($sformatf("reprog err k=%0d", k), 32'(cfg_err), 32'd0);
    end

    // Reset lands at cnt=3 of D=8; divisor must return to the default of 2.
    drive(1'b0, 2'b01, 1'b0, 2'd0, 16'd0);
    cyc();
    check("rst clk_out", 32'(clk_out), 32'd0);
    check("rst tick", 32'(tick), 32'd0);
    check("rst pending", 32'(pending), 32'd0);
    check("rst ready", 32'(cfg_ready), 32'd1);
    check("rst err", 32'(cfg_err), 32'd0);
    drive(1'b1, 2'b01, 1'b0, 2'd0, 16'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("post-rst clk k=%0d", k), 32'(clk_out[0]), 32'((k % 2) == 0));
      check($sformatf("post-rst tick k=%0d", k), 32'(tick[0]), 32'((k % 2) == 0));
    end

    // Maximum divisor: one tick and 32767 high cycles per 65535-cycle period.
    drive(1'b1, 2'b00, 1'b1, 2'd0, 16'hFFFF);
    cyc();
    drive(1'b1, 2'b00, 1'b0, 2'd0, 16'd0);
    cyc();
    check("max pending clear", 32'(pending[0]), 32'd0);
    drive(1'b1, 2'b01, 1'b0, 2'd0, 16'd0);
    ticks = 0;
    highs = 0;
    for (int k = 0; k < 65535; k++) begin
      cyc();
      if (k == 0) check("max first tick", 32'(tick[0]), 32'd1);
      if (tick[0] === 1'b1) ticks++;
      if (clk_out[0] === 1'b1) highs++;
    end
    check("max tick count", 32'(ticks), 32'd1);
    check("max high count", 32'(highs), 32'd32767);
    cyc();
    check("max next tick", 32'(tick[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
